// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Redirect-select encodings, bus width and the word-alignment helper live here.
package if_stage_pkg;

  localparam int          IF_TO_ID_BUS_WIDTH = 64;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEL_SEQ  = 2'd0,
    NPC_SEL_BR   = 2'd1,
    NPC_SEL_TRAP = 2'd2
  } npc_sel_e;

  // Instruction fetches are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_npc_sel.sv
// Next-PC priority mux for the fetch stage: trap > branch > sequential.
// Purely combinational; the result is word aligned and the sequential add wraps.
module if_npc_sel
  import if_stage_pkg::*;
(
  input  logic [31:0] if_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_target,
  output logic [31:0] nextpc
);

  npc_sel_e    npc_sel_s;
  logic [31:0] raw_npc_s;

  // Encode the redirect source by priority.
  always_comb begin
    npc_sel_s = NPC_SEL_SEQ;
    if (trap_valid) begin
      npc_sel_s = NPC_SEL_TRAP;
    end else if (br_taken) begin
      npc_sel_s = NPC_SEL_BR;
    end else begin
      npc_sel_s = NPC_SEL_SEQ;
    end
  end

  // Select the raw next PC and force word alignment.
  always_comb begin
    raw_npc_s = if_pc + 32'd4;
    case (npc_sel_s)
      NPC_SEL_SEQ:  raw_npc_s = if_pc + 32'd4;
      NPC_SEL_BR:   raw_npc_s = br_target;
      NPC_SEL_TRAP: raw_npc_s = trap_target;
      default:      raw_npc_s = if_pc + 32'd4;
    endcase
    nextpc = align_pc(raw_npc_s);
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the fetch PC, picks the next PC and drives the
// synchronous IROM so ID always sees the word for the PC it has latched.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_allow_in,
  input  logic                          br_taken,
  input  logic [31:0]                   br_target,
  input  logic                          trap_valid,
  input  logic [31:0]                   trap_target,
  output logic [31:0]                   irom_addr,
  output logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus,
  output logic                          if_to_id_valid
);

  localparam logic [31:0] PRE_RESET_PC = RESET_PC - 32'd4;

  logic [31:0] if_pc_r;
  logic        if_valid_r;
  logic [31:0] id_pc_hold_r;

  logic [31:0] nextpc_s;
  logic        flush_s;
  logic        if_ready_go_s;
  logic        if_allow_in_s;
  logic        handoff_s;

  if_npc_sel u_npc_sel (
    .if_pc       (if_pc_r),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .trap_valid  (trap_valid),
    .trap_target (trap_target),
    .nextpc      (nextpc_s)
  );

  // Handshake: a redirect always lets IF reload, even while ID is stalled.
  always_comb begin
    flush_s        = br_taken | trap_valid;
    if_ready_go_s  = 1'b1;
    if_allow_in_s  = ~if_valid_r | (id_allow_in & if_ready_go_s) | flush_s;
    if_to_id_valid = if_valid_r & ~flush_s;
    handoff_s      = if_to_id_valid & id_allow_in;
    if_to_id_bus   = {if_pc_r + 32'd4, if_pc_r};
  end

  // IROM data lags the address by one edge, so keep ID's PC on the address while it holds.
  always_comb begin
    if (handoff_s) begin
      irom_addr = if_pc_r;
    end else begin
      irom_addr = id_pc_hold_r;
    end
  end

  // Fetch PC and valid register.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc_r    <= PRE_RESET_PC;
      if_valid_r <= 1'b0;
    end else if (if_allow_in_s) begin
      if_pc_r    <= nextpc_s;
      if_valid_r <= 1'b1;
    end
  end

  // Copy of the PC currently owned by ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_hold_r <= PRE_RESET_PC;
    end else if (handoff_s) begin
      id_pc_hold_r <= if_pc_r;
    end
  end

endmodule
